pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Pipeline control unit for the 4-stage integer core (IF, ID, EX, MEM). It generates per-stage stall and flush controls and the redirect PC consumed by the IF pipeline register. It owns the exception/interrupt state: EPC, exception code, interrupt enable and mask. It also sequences exception entry, ERET return, load-use bubbles, bus-busy stalls and HALT/wake.

Parameters:
ADDR_W, 30, word address width (PC, EPC, vectors)
DATA_W, 32, control-register data width
EXC_VECTOR, 30'h0000_0008, word address of the exception/interrupt handler
IRQ_N, 8, number of interrupt request lines

Ports:
clk  in  1  clock, rising edge
reset_  in  1  synchronous reset, active-high
if_busy  in  1  instruction bus not ready
mem_busy  in  1  data bus not ready
ld_hazard  in  1  load-use hazard detected in ID
id_pc  in  ADDR_W  PC of instruction in ID
id_en  in  1  ID holds a valid instruction
mem_pc  in  ADDR_W  PC of instruction in MEM
mem_en  in  1  MEM holds a valid instruction
mem_exp_code  in  3  exception raised by MEM instruction; 0 = none
mem_eret  in  1  MEM instruction is ERET
mem_halt  in  1  MEM instruction is HALT
irq  in  IRQ_N  level-sensitive interrupt requests
cr_we  in  1  control register write, committed from MEM
cr_addr  in  2  control register index
cr_wdata  in  DATA_W  write data
cr_rdata  out  DATA_W  combinational read data at cr_addr
if_stall, id_stall, ex_stall, mem_stall  out  1 each  hold stage register
if_flush, id_flush, ex_flush, mem_flush  out  1 each  load bubble into stage register
new_pc  out  ADDR_W  redirect target, valid when if_flush=1
int_en  out  1  current interrupt enable

Behaviour:
- All stall/flush/new_pc outputs are combinational from inputs plus state. State registers update on the rising clk edge.
- Reset (reset_=1, synchronous) forces:
  - state=RUN, epc=0, exp_code=0, int_en=0, pre_int_en=0, int_mask=all ones.
  - All stall outputs=1 and all flush outputs=0 during the reset cycle.
  - new_pc=0.
- Registers by cr_addr:
  - 0 STATUS: bit0=int_en, bit1=pre_int_en.
  - 1 INT_MASK: low IRQ_N bits; a 1 masks the line.
  - 2 EXP_CODE: low 3 bits.
  - 3 EPC: low ADDR_W bits.
  - Unused read bits are 0.
- Definitions used below:
  - exc = mem_en & (mem_exp_code≠0)
  - eret = mem_en & mem_eret
  - irq_p = |(irq & ~int_mask)
  - int_req = int_en & irq_p
- Priority in RUN, evaluated only when mem_busy=0 and if_busy=0, highest first:
  1. exc: all four flushes=1, new_pc=EXC_VECTOR. Next edge: epc←mem_pc, exp_code←mem_exp_code, pre_int_en←int_en, int_en←0.
  2. eret: all four flushes=1, new_pc=epc. Next edge: int_en←pre_int_en.
  3. int_req & id_en: all four flushes=1, new_pc=EXC_VECTOR. Next edge: epc←id_pc, exp_code←3'd1, pre_int_en←int_en, int_en←0.
  4. mem_en & mem_halt: flush IF, ID, EX. Next edge: state←HALT, epc←mem_pc+1 (wraps modulo 2^ADDR_W).
  5. ld_hazard: if_stall=1, id_flush=1; all other controls 0.
  6. Otherwise: all controls 0.
- Bus busy: mem_busy|if_busy forces all four stalls=1 and all flushes=0. No state update occurs, including cr writes, and any exc/eret/int is deferred until both busy inputs are low.
- cr_we writes at the edge when not busy. Events 1–3 override a same-cycle cr write to STATUS/EXP_CODE/EPC; INT_MASK writes still occur.
- HALT state:
  - All four stalls=1.
  - When irq_p & int_en: all four flushes=1, new_pc=EXC_VECTOR, epc unchanged (already points to HALT+1), exp_code←1, pre_int_en←int_en, int_en←0, state←RUN.
  - Masked or disabled irq keeps the unit in HALT indefinitely.
- Simultaneous exc and eret in one cycle: exc wins.
- Reset in HALT returns to RUN.

Test Plan:
1. Reset held 2 cycles → all stalls=1, flushes=0, cr_rdata(0)=0, INT_MASK=0xFF. After release with idle inputs → all controls 0.
2. mem_en=1, mem_exp_code=3'd2, mem_pc=0x40 → same cycle all flushes=1, new_pc=0x8. Next cycle EPC=0x40, EXP_CODE=2, int_en=0.
3. Write STATUS=1 and INT_MASK=0xFE, then irq=0x01, id_en=1, id_pc=0x55 → flush all, new_pc=0x8, EPC=0x55, STATUS=2. Then mem_eret=1 → new_pc=0x55, int_en=1.
4. ld_hazard=1 for 2 cycles → if_stall=1, id_flush=1 each cycle; other controls 0.
5. mem_busy=1 with mem_exp_code=1 → all stalls=1, no flush, EPC unchanged. Drop mem_busy → exception taken that cycle.
6. mem_halt at mem_pc=0x3FFFFFFF → IF/ID/EX flushed, then HALT with all stalls=1 and EPC=0. Raise enabled irq → flush all, new_pc=0x8, state RUN.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/redirect control and exception state for the 4-stage core.
// Rev 1.0 - initial release.
`default_nettype none

module pipe_ctrl #(
  parameter int                ADDR_W     = 30,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = 30'h0000_0008,
  parameter int                IRQ_N      = 8
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              if_busy,
  input  logic              mem_busy,
  input  logic              ld_hazard,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic              id_en,
  input  logic [ADDR_W-1:0] mem_pc,
  input  logic              mem_en,
  input  logic [2:0]        mem_exp_code,
  input  logic              mem_eret,
  input  logic              mem_halt,
  input  logic [IRQ_N-1:0]  irq,
  input  logic              cr_we,
  input  logic [1:0]        cr_addr,
  input  logic [DATA_W-1:0] cr_wdata,
  output logic [DATA_W-1:0] cr_rdata,
  output logic              if_stall,
  output logic              id_stall,
  output logic              ex_stall,
  output logic              mem_stall,
  output logic              if_flush,
  output logic              id_flush,
  output logic              ex_flush,
  output logic              mem_flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic              int_en
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  epc_q, epc_d;
  logic [2:0]         exp_code_q, exp_code_d;
  logic               int_en_q, int_en_d;
  logic               pre_int_en_q, pre_int_en_d;
  logic [IRQ_N-1:0]   int_mask_q, int_mask_d;

  logic w_busy, w_exc, w_eret, w_irq_p, w_int_req, w_evt;
  logic w_unused;

  assign w_busy    = mem_busy | if_busy;
  assign w_exc     = mem_en & (mem_exp_code != 3'd0);
  assign w_eret    = mem_en & mem_eret;
  assign w_irq_p   = |(irq & ~int_mask_q);
  assign w_int_req = int_en_q & w_irq_p;
  // Redirecting events in RUN take precedence over software writes to STATUS/EXP_CODE/EPC.
  assign w_evt     = (state_q == ST_RUN) & (w_exc | w_eret | (w_int_req & id_en));
  assign w_unused  = &{1'b0, cr_wdata};
  assign int_en    = int_en_q;

  always_comb begin
    state_d      = state_q;
    epc_d        = epc_q;
    exp_code_d   = exp_code_q;
    int_en_d     = int_en_q;
    pre_int_en_d = pre_int_en_q;
    int_mask_d   = int_mask_q;
    {if_stall, id_stall, ex_stall, mem_stall} = 4'b0000;
    {if_flush, id_flush, ex_flush, mem_flush} = 4'b0000;
    new_pc = '0;

    if (reset_ || w_busy) begin
      {if_stall, id_stall, ex_stall, mem_stall} = 4'b1111;
    end else begin
      if (cr_we && (cr_addr == 2'd1 || !w_evt)) begin
        case (cr_addr)
          2'd0: begin
            int_en_d     = cr_wdata[0];
            pre_int_en_d = cr_wdata[1];
          end
          2'd1:    int_mask_d = cr_wdata[IRQ_N-1:0];
          2'd2:    exp_code_d = cr_wdata[2:0];
          default: epc_d      = cr_wdata[ADDR_W-1:0];
        endcase
      end

      if (state_q == ST_HALT) begin
        {if_stall, id_stall, ex_stall, mem_stall} = 4'b1111;
        if (w_irq_p && int_en_q) begin
          // epc already holds the instruction after HALT.
          {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
          new_pc       = EXC_VECTOR;
          exp_code_d   = 3'd1;
          pre_int_en_d = int_en_q;
          int_en_d     = 1'b0;
          state_d      = ST_RUN;
        end
      end else if (w_exc) begin
        {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
        new_pc       = EXC_VECTOR;
        epc_d        = mem_pc;
        exp_code_d   = mem_exp_code;
        pre_int_en_d = int_en_q;
        int_en_d     = 1'b0;
      end else if (w_eret) begin
        {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
        new_pc   = epc_q;
        int_en_d = pre_int_en_q;
      end else if (w_int_req && id_en) begin
        {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
        new_pc       = EXC_VECTOR;
        epc_d        = id_pc;
        exp_code_d   = 3'd1;
        pre_int_en_d = int_en_q;
        int_en_d     = 1'b0;
      end else if (mem_en && mem_halt) begin
        {if_flush, id_flush, ex_flush} = 3'b111;
        epc_d   = mem_pc + ADDR_W'(1);
        state_d = ST_HALT;
      end else if (ld_hazard) begin
        if_stall = 1'b1;
        id_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_) begin
      state_q      <= ST_RUN;
      epc_q        <= '0;
      exp_code_q   <= '0;
      int_en_q     <= 1'b0;
      pre_int_en_q <= 1'b0;
      int_mask_q   <= '1;
    end else begin
      state_q      <= state_d;
      epc_q        <= epc_d;
      exp_code_q   <= exp_code_d;
      int_en_q     <= int_en_d;
      pre_int_en_q <= pre_int_en_d;
      int_mask_q   <= int_mask_d;
    end
  end

  always_comb begin
    cr_rdata = '0;
    case (cr_addr)
      2'd0:    cr_rdata = DATA_W'({pre_int_en_q, int_en_q});
      2'd1:    cr_rdata = DATA_W'(int_mask_q);
      2'd2:    cr_rdata = DATA_W'(exp_code_q);
      default: cr_rdata = DATA_W'(epc_q);
    endcase
  end

endmodule

`default_nettype wire
